pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DIV_CYCLES, 32, number of cycles a divide occupies EXE.
- EXC_ENTRY, 32'hBFC0_0380, exception handler entry PC.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- cpu_clk_50M  in  1  sole clock; all state updates on its rising edge.
- cpu_rst_n  in  1  synchronous reset, active-high (asserted when 1), despite the name.
- stallreq_id  in  1  load-use hazard from ID.
- stallreq_mem  in  1  data-memory wait from MEM.
- div_start  in  1  single-cycle pulse: EXE begins a divide.
- exc_req  in  1  single-cycle pulse: MEM commits an exception or eret.
- exc_is_eret  in  1  qualifies exc_req: 1 = eret, 0 = exception.
- cp0_epc  in  32  return address for eret.
- stall  out  4  STALL_BUS: [0] PC, [1] IF/ID, [2] ID/EXE, [3] EXE/MEM; STOP=1, NOSTOP=0.
- flush  out  1  clears all pipeline registers to reset values.
- redirect_valid  out  1  PC must load redirect_pc next edge.
- redirect_pc  out  32  redirect target.
- div_busy  out  1  divide in progress.
- div_done  out  1  single-cycle pulse: divide result valid this cycle.
- div_cancel  out  1  single-cycle pulse: in-flight divide aborted.

Function
REQ-003 FSM states SHALL be IDLE, DIV_BUSY and FLUSH.
REQ-004 IDLE SHALL go to FLUSH on exc_req, else to DIV_BUSY on div_start, else stay in IDLE.
REQ-005 DIV_BUSY SHALL load a 6-bit counter with 0 on entry and increment it each cycle.
REQ-006 DIV_BUSY SHALL assert div_done when the counter equals DIV_CYCLES-1, then return to IDLE.
REQ-007 An exc_req in DIV_BUSY SHALL go to FLUSH, clear the counter, pulse div_cancel the next cycle and suppress div_done.
REQ-008 FLUSH SHALL last exactly one cycle, then go to IDLE; exc_req and div_start arriving in FLUSH SHALL be ignored.
REQ-009 flush, redirect_valid, redirect_pc and div_cancel SHALL be registered: asserted the cycle after exc_req, for one cycle.
REQ-010 redirect_pc SHALL be cp0_epc (sampled with exc_req) when exc_is_eret=1, else EXC_ENTRY.
REQ-011 stall SHALL be combinational: the highest stalling stage k sets stall[k:0]=STOP and the rest NOSTOP.
REQ-012 Encodings (stall[3:0]): stallreq_mem → 1111; DIV_BUSY or div_start → 0111; stallreq_id → 0011; none → 0000.
REQ-013 While flush=1, stall SHALL be 0000 regardless of requests.
REQ-014 div_busy SHALL equal 1 exactly while the FSM is in DIV_BUSY.
REQ-015 The last DIV_BUSY cycle (div_done=1) SHALL still drive stall=0111; stall releases the following cycle.
REQ-016 div_start together with exc_req in IDLE SHALL resolve to FLUSH; no divide starts.

Reset
REQ-017 While cpu_rst_n=1 at a clock edge, the FSM SHALL enter IDLE and clear the counter.
REQ-018 Reset SHALL drive flush=0, redirect_valid=0, redirect_pc=32'h0, div_done=0 and div_cancel=0; stall SHALL then follow only stallreq_id and stallreq_mem.
REQ-019 Reset SHALL take precedence over exc_req and div_start arriving in the same cycle; reset mid-divide SHALL abort it without asserting div_cancel.

Structure
REQ-020 STALL_BUS, STOP, NOSTOP, ZERO_WORD, PC_INIT and the EXC_ENTRY default SHALL live in the shared defines.
REQ-021 FSM state encodings SHALL stay local to the block.
REQ-022 The divide counter SHALL be a sub-module div_timer (ports: start, clear, busy, done).
REQ-023 The stall priority encoder SHALL be inline.

Verification
REQ-024 stallreq_id=1 for one cycle in IDLE → stall=0011 that cycle only, flush=0.
REQ-025 div_start pulse with DIV_CYCLES=32 → stall=0111 for 33 cycles, div_done on the 33rd (counter=31), then stall=0000.
REQ-026 exc_req (exc_is_eret=0) at divide cycle 10 → next cycle flush=1, redirect_pc=32'hBFC00380, div_cancel=1, stall=0000; no div_done ever.
REQ-027 exc_req with exc_is_eret=1, cp0_epc=32'h8000_0124, together with stallreq_mem=1 → stall=1111 that cycle; next cycle flush=1, redirect_pc=32'h80000124, stall=0000.
REQ-028 cpu_rst_n=1 at divide cycle 5 with div_start=1 → IDLE next cycle, div_busy=0, all outputs at reset values, no div_cancel.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: stall bus layout, stall levels and reset/exception addresses.
package pipeline_ctrl_pkg;

  localparam int          STALL_BUS     = 4;
  localparam logic        STOP          = 1'b1;
  localparam logic        NOSTOP        = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [31:0] PC_INIT       = 32'hBFC0_0000;
  localparam logic [31:0] EXC_ENTRY_DEF = 32'hBFC0_0380;
  localparam int          DIV_CNT_W     = 6;

  typedef logic [STALL_BUS-1:0] stall_bus_t;

  // Stage k stalls itself and every stage behind it.
  function automatic stall_bus_t stall_upto(input int k);
    stall_bus_t mask;
    for (int i = 0; i < STALL_BUS; i++) begin
      mask[i] = (i <= k) ? STOP : NOSTOP;
    end
    return mask;
  endfunction

endpackage

// File: rtl/div_timer.sv
// Counts the cycles of one divide; done marks the final cycle, clear aborts it.
module div_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic srst,
  input  logic start,
  input  logic clear,
  output logic busy,
  output logic done
);

  localparam logic [DIV_CNT_W-1:0] LAST = DIV_CNT_W'(DIV_CYCLES - 1);

  logic [DIV_CNT_W-1:0] cnt_reg;
  logic                 busy_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (busy_reg) begin
      if (cnt_reg == LAST) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + DIV_CNT_W'(1);
      end
    end else if (start) begin
      busy_reg <= 1'b1;
      cnt_reg  <= '0;
    end
  end

  assign busy = busy_reg;
  assign done = busy_reg && (cnt_reg == LAST);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall priority, multi-cycle divide tracking and exception/eret flush with redirect.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          DIV_CYCLES = 32,
  parameter logic [31:0] EXC_ENTRY  = EXC_ENTRY_DEF
) (
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst_n,
  input  logic                 stallreq_id,
  input  logic                 stallreq_mem,
  input  logic                 div_start,
  input  logic                 exc_req,
  input  logic                 exc_is_eret,
  input  logic [31:0]          cp0_epc,
  output logic [STALL_BUS-1:0] stall,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 div_busy,
  output logic                 div_done,
  output logic                 div_cancel
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t      state_reg;
  logic        flush_reg;
  logic        redirect_valid_reg;
  logic [31:0] redirect_pc_reg;
  logic        div_cancel_reg;

  logic tmr_start, tmr_clear, tmr_busy, tmr_done;
  logic div_stall;

  assign tmr_start = (state_reg == IDLE) && div_start && !exc_req;
  assign tmr_clear = (state_reg == DIV_BUSY) && exc_req;

  div_timer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_timer (
    .clk  (cpu_clk_50M),
    .srst (cpu_rst_n),
    .start(tmr_start),
    .clear(tmr_clear),
    .busy (tmr_busy),
    .done (tmr_done)
  );

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n) begin
      state_reg          <= IDLE;
      flush_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= ZERO_WORD;
      div_cancel_reg     <= 1'b0;
    end else begin
      flush_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= ZERO_WORD;
      div_cancel_reg     <= 1'b0;
      case (state_reg)
        IDLE, DIV_BUSY: begin
          if (exc_req) begin
            state_reg          <= FLUSH;
            flush_reg          <= 1'b1;
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= exc_is_eret ? cp0_epc : EXC_ENTRY;
            div_cancel_reg     <= (state_reg == DIV_BUSY);
          end else if (state_reg == IDLE) begin
            if (div_start) state_reg <= DIV_BUSY;
          end else if (tmr_done || !tmr_busy) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Divide stalls are masked during reset so stall tracks only the stage requests.
  assign div_stall = !cpu_rst_n && ((state_reg == DIV_BUSY) || div_start);

  always_comb begin
    stall = {STALL_BUS{NOSTOP}};
    if (flush_reg)         stall = {STALL_BUS{NOSTOP}};
    else if (stallreq_mem) stall = stall_upto(3);
    else if (div_stall)    stall = stall_upto(2);
    else if (stallreq_id)  stall = stall_upto(1);
  end

  assign flush          = flush_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign div_cancel     = div_cancel_reg;
  assign div_busy       = (state_reg == DIV_BUSY);
  assign div_done       = tmr_done && (state_reg == DIV_BUSY) && !exc_req && !cpu_rst_n;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; stimulus queues expectations, a monitor checks them.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sid, smem, ds, exc, eret;
  logic [31:0] epc;
  logic [3:0]  stall;
  logic        flush, rv, busy, done, cancel;
  logic [31:0] rpc;

  int cycle = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [40:0] vec;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  pipeline_ctrl #(
    .DIV_CYCLES(32),
    .EXC_ENTRY (32'hBFC0_0380)
  ) dut (
    .cpu_clk_50M   (clk),
    .cpu_rst_n     (rst),
    .stallreq_id   (sid),
    .stallreq_mem  (smem),
    .div_start     (ds),
    .exc_req       (exc),
    .exc_is_eret   (eret),
    .cp0_epc       (epc),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(rv),
    .redirect_pc   (rpc),
    .div_busy      (busy),
    .div_done      (done),
    .div_cancel    (cancel)
  );

  // vec = {stall, flush, redirect_valid, redirect_pc, div_busy, div_done, div_cancel}
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
      exp_t e;
      logic [40:0] act;
      e   = exp_q.pop_front();
      act = {stall, flush, rv, rpc, busy, done, cancel};
      n_tests++;
      if (act !== e.vec) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: stall=%b flush=%b rv=%b pc=%h busy=%b done=%b cancel=%b, required stall=%b flush=%b rv=%b pc=%h busy=%b done=%b cancel=%b",
                 e.name, cycle, act[40:37], act[36], act[35], act[34:3], act[2], act[1], act[0],
                 e.vec[40:37], e.vec[36], e.vec[35], e.vec[34:3], e.vec[2], e.vec[1], e.vec[0]);
      end else begin
        $display("[TB] ok %s cyc=%0d stall=%b flush=%b pc=%h busy=%b done=%b cancel=%b",
                 e.name, cycle, act[40:37], act[36], act[34:3], act[2], act[1], act[0]);
      end
    end
  end

  task automatic step(input logic r, input logic i_id, input logic i_mem, input logic i_ds,
                      input logic i_exc, input logic i_eret, input logic [31:0] i_epc,
                      input logic [3:0] x_stall, input logic x_flush, input logic [31:0] x_pc,
                      input logic x_busy, input logic x_done, input logic x_cancel,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; sid = i_id; smem = i_mem; ds = i_ds; exc = i_exc; eret = i_eret; epc = i_epc;
    e.cyc  = cycle;
    e.name = nm;
    e.vec  = {x_stall, x_flush, x_flush, x_pc, x_busy, x_done, x_cancel};
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm);
    step(0, 0, 0, 0, 0, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 0, 0, nm);
  endtask

  // Issues div_start then 32 busy cycles; div_done expected on the last.
  task automatic full_divide(input string nm);
    step(0, 0, 0, 1, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 0, 0, 0, {nm, "_start"});
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 1, (i == 31), 0, {nm, "_busy"});
    end
    idle({nm, "_release"});
  endtask

  initial begin
    rst = 1; sid = 0; smem = 0; ds = 0; exc = 0; eret = 0; epc = 32'h0;
    repeat (2) @(posedge clk);

    // Reset: outputs at reset values, stall follows only stage requests
    step(1, 0, 0, 0, 0, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 0, 0, "rst_zero");
    step(1, 1, 0, 0, 0, 0, 32'h0, 4'b0011, 0, 32'h0, 0, 0, 0, "rst_id");
    step(1, 0, 1, 0, 0, 0, 32'h0, 4'b1111, 0, 32'h0, 0, 0, 0, "rst_mem");
    step(1, 0, 0, 1, 1, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 0, 0, "rst_ds_exc");
    idle("rst_release");

    // Single-cycle ID hazard
    step(0, 1, 0, 0, 0, 0, 32'h0, 4'b0011, 0, 32'h0, 0, 0, 0, "id_stall");
    idle("id_release");
    step(0, 1, 1, 0, 0, 0, 32'h0, 4'b1111, 0, 32'h0, 0, 0, 0, "mem_over_id");

    // Full divide with stage requests layered on top
    step(0, 0, 0, 1, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 0, 0, 0, "div_start");
    for (int i = 0; i < 32; i++) begin
      if (i == 3)
        step(0, 1, 0, 0, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 1, 0, 0, "div_over_id");
      else if (i == 4)
        step(0, 0, 1, 0, 0, 0, 32'h0, 4'b1111, 0, 32'h0, 1, 0, 0, "mem_over_div");
      else
        step(0, 0, 0, 0, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 1, (i == 31), 0, "div_busy");
    end
    idle("div_release");

    // Exception at divide cycle 10; requests during FLUSH are ignored
    step(0, 0, 0, 1, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 0, 0, 0, "div2_start");
    for (int i = 0; i < 9; i++)
      step(0, 0, 0, 0, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 1, 0, 0, "div2_busy");
    step(0, 0, 0, 0, 1, 0, 32'h1234_5678, 4'b0111, 0, 32'h0, 1, 0, 0, "div2_exc");
    step(0, 0, 0, 1, 1, 1, 32'h0000_0040, 4'b0000, 1, 32'hBFC0_0380, 0, 0, 1, "div2_flush");
    for (int i = 0; i < 3; i++) idle("post_flush_idle");

    // Eret with simultaneous memory stall
    step(0, 0, 1, 0, 1, 1, 32'h8000_0124, 4'b1111, 0, 32'h0, 0, 0, 0, "eret_mem");
    step(0, 0, 1, 0, 0, 0, 32'h0, 4'b0000, 1, 32'h8000_0124, 0, 0, 0, "eret_flush");
    idle("eret_release");

    // div_start with exc_req in IDLE: flush wins, no divide
    step(0, 0, 0, 1, 1, 0, 32'h0, 4'b0111, 0, 32'h0, 0, 0, 0, "ds_exc_same");
    step(0, 0, 0, 0, 0, 0, 32'h0, 4'b0000, 1, 32'hBFC0_0380, 0, 0, 0, "ds_exc_flush");
    idle("ds_exc_idle");

    // Exception on the final divide cycle suppresses div_done
    step(0, 0, 0, 1, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 0, 0, 0, "div3_start");
    for (int i = 0; i < 31; i++)
      step(0, 0, 0, 0, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 1, 0, 0, "div3_busy");
    step(0, 0, 0, 0, 1, 1, 32'h8000_0200, 4'b0111, 0, 32'h0, 1, 0, 0, "div3_exc_last");
    step(0, 0, 0, 0, 0, 0, 32'h0, 4'b0000, 1, 32'h8000_0200, 0, 0, 1, "div3_flush");
    idle("div3_idle");

    // Reset at divide cycle 5 with div_start: abort without cancel
    step(0, 0, 0, 1, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 0, 0, 0, "div4_start");
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, 0, 32'h0, 4'b0111, 0, 32'h0, 1, 0, 0, "div4_busy");
    step(1, 0, 0, 1, 0, 0, 32'h0, 4'b0000, 0, 32'h0, 1, 0, 0, "div4_rst");
    idle("div4_after_rst");
    idle("div4_idle");

    // Counter restarts cleanly after the aborted divide
    full_divide("div5");

    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (exp_q.size() > 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
